// File: rtl/pifo_drain_checker.sv
// Drain-side sink for the PIFO bench: throttled dequeue requests, one response per request,
// priority-order checking, packet count and pointer XOR checksum for the drain phase.
module pifo_drain_checker #(
    parameter int PTR_WIDTH      = 16,
    parameter int PRIO_WIDTH     = 16,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i__drain_phase,
    input  logic [CNT_WIDTH-1:0]  i__expected_packets,
    input  logic [7:0]            i__deq_rate,
    input  logic [7:0]            i__deq_seed,
    input  logic                  i__pifo_empty,
    output logic                  o__pifo_deq_req,
    input  logic                  i__pifo_deq_valid,
    input  logic [PTR_WIDTH-1:0]  i__pifo_deq_pointer,
    input  logic [PRIO_WIDTH-1:0] i__pifo_deq_priority,
    output logic [CNT_WIDTH-1:0]  o__num_pkts_received,
    output logic [CNT_WIDTH-1:0]  o__num_order_errors,
    output logic [PTR_WIDTH-1:0]  o__pointer_checksum,
    output logic                  o__unexpected_resp,
    output logic                  o__timeout,
    output logic                  o__done
);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                  state_reg;
    logic                    drain_prev_reg;
    logic [CNT_WIDTH-1:0]    expected_reg;
    logic [7:0]              lfsr_reg;
    logic [WAIT_W-1:0]       wait_cnt_reg;
    logic [PRIO_WIDTH-1:0]   last_prio_reg;
    logic                    have_last_reg;
    logic                    req_reg;
    logic [CNT_WIDTH-1:0]    received_reg;
    logic [CNT_WIDTH-1:0]    errors_reg;
    logic [PTR_WIDTH-1:0]    checksum_reg;
    logic                    unexpected_reg;
    logic                    timeout_reg;
    logic                    done_reg;

    logic                    drain_rise;
    logic                    issue_ok;
    logic [7:0]              lfsr_step;
    logic [CNT_WIDTH-1:0]    received_inc;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    assign lfsr_step    = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    assign drain_rise   = i__drain_phase && !drain_prev_reg;
    assign issue_ok     = !i__pifo_empty && ((i__deq_rate == 8'hFF) || (lfsr_reg < i__deq_rate));
    assign received_inc = received_reg + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            drain_prev_reg <= 1'b0;
            expected_reg   <= '0;
            lfsr_reg       <= (i__deq_seed == 8'h00) ? 8'h01 : i__deq_seed;
            wait_cnt_reg   <= '0;
            last_prio_reg  <= '0;
            have_last_reg  <= 1'b0;
            req_reg        <= 1'b0;
            received_reg   <= '0;
            errors_reg     <= '0;
            checksum_reg   <= '0;
            unexpected_reg <= 1'b0;
            timeout_reg    <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            drain_prev_reg <= i__drain_phase;
            req_reg        <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (drain_rise) begin
                        received_reg   <= '0;
                        errors_reg     <= '0;
                        checksum_reg   <= '0;
                        last_prio_reg  <= '0;
                        have_last_reg  <= 1'b0;
                        unexpected_reg <= 1'b0;
                        timeout_reg    <= 1'b0;
                        expected_reg   <= i__expected_packets;
                        if (i__expected_packets == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!i__drain_phase) begin
                        state_reg <= IDLE;
                    end else if (issue_ok) begin
                        req_reg      <= 1'b1;
                        state_reg    <= WAIT;
                        wait_cnt_reg <= '0;
                        lfsr_reg     <= lfsr_step;
                    end
                end
                WAIT: begin
                    // WAIT is entered together with the request pulse, so a same-cycle response counts.
                    if (i__pifo_deq_valid) begin
                        received_reg  <= received_inc;
                        checksum_reg  <= checksum_reg ^ i__pifo_deq_pointer;
                        last_prio_reg <= i__pifo_deq_priority;
                        have_last_reg <= 1'b1;
                        if (have_last_reg && (i__pifo_deq_priority < last_prio_reg) &&
                            (errors_reg != {CNT_WIDTH{1'b1}})) begin
                            errors_reg <= errors_reg + CNT_WIDTH'(1);
                        end
                        if (received_inc == expected_reg) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else if (!i__drain_phase) begin
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= ISSUE;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                        if (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                            timeout_reg <= 1'b1;
                            state_reg   <= DONE;
                            done_reg    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!i__drain_phase) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            // Placed after the case so a stray response still flags even on a drain-start cycle.
            if (i__pifo_deq_valid && (state_reg != WAIT)) begin
                unexpected_reg <= 1'b1;
            end
        end
    end

    assign o__pifo_deq_req      = req_reg;
    assign o__num_pkts_received = received_reg;
    assign o__num_order_errors  = errors_reg;
    assign o__pointer_checksum  = checksum_reg;
    assign o__unexpected_resp   = unexpected_reg;
    assign o__timeout           = timeout_reg;
    assign o__done              = done_reg;
endmodule
